// File: rtl/jp_responder.sv
// Device-side NES controller (4021-style) emulator: samples btn_in on latch and
// shifts it out serially on host clock rising edges, with synchronized and filtered strobes.
module jp_responder #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] btn_in,
  input  logic       jp_clk_in,
  input  logic       jp_latch_in,
  output logic       jp_data_out,
  output logic       poll_out,
  output logic [3:0] shift_cnt_out
);

  localparam int unsigned CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] FLIM = CW'(FILTER_CYCLES - 1);
  // Index 0 is the host clock (idles high), index 1 is the latch (idles low).
  localparam logic [1:0] IDLE = 2'b01;

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [SYNC_STAGES-1:0] sync_d [2];
  logic [CW-1:0]          fcnt_q [2];
  logic [CW-1:0]          fcnt_d [2];
  logic [1:0]             filt_q, filt_d;
  logic [1:0]             prev_q, prev_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   data_q, data_d;
  logic                   poll_q, poll_d;
  logic                   clk_rise, latch_fall;

  always_comb begin
    raw = {jp_latch_in, jp_clk_in};
    for (int unsigned i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      // Count only while the synchronized sample disagrees; agreement restarts the count.
      if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
        if (fcnt_q[i] == FLIM) filt_d[i] = sync_q[i][SYNC_STAGES-1];
        else                   fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
    prev_d     = filt_q;
    clk_rise   = filt_q[0] & ~prev_q[0];
    latch_fall = ~filt_q[1] & prev_q[1];

    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    poll_d  = latch_fall;
    if (filt_q[1]) begin
      shreg_d = btn_in;
      cnt_d   = '0;
    end else if (clk_rise && !latch_fall) begin
      shreg_d = {1'b0, shreg_q[7:1]};
      if (cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
    end
    data_d = (cnt_q < 4'd8) ? ~shreg_q[0] : 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < 2; i++) begin
        sync_q[i] <= {SYNC_STAGES{IDLE[i]}};
        fcnt_q[i] <= '0;
      end
      filt_q  <= IDLE;
      prev_q  <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= 1'b1;
      poll_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        sync_q[i] <= sync_d[i];
        fcnt_q[i] <= fcnt_d[i];
      end
      filt_q  <= filt_d;
      prev_q  <= prev_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      poll_q  <= poll_d;
    end
  end

  assign jp_data_out   = data_q;
  assign poll_out      = poll_q;
  assign shift_cnt_out = cnt_q;

endmodule

// File: tb/tb_jp_responder.sv
// Bench for jp_responder: host-side reads compared against a protocol-level model
// (bit k of a read is ~btn[k] for k<8, else 0; count is min(shifts, 8)).
module tb_jp_responder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned FILT = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] btn_in = '0;
  logic       jp_clk_in = 1'b1;
  logic       jp_latch_in = 1'b0;
  logic       jp_data_out;
  logic       poll_out;
  logic [3:0] shift_cnt_out;

  int n_checks = 0;
  int n_fail   = 0;
  int poll_cnt = 0;

  always #5 clk_in = ~clk_in;

  jp_responder #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .btn_in        (btn_in),
    .jp_clk_in     (jp_clk_in),
    .jp_latch_in   (jp_latch_in),
    .jp_data_out   (jp_data_out),
    .poll_out      (poll_out),
    .shift_cnt_out (shift_cnt_out)
  );

  // Counts cycles with poll high, so a stretched pulse shows up as a count above 1.
  always @(negedge clk_in) if (poll_out === 1'b1) poll_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  function automatic int exp_bit(input logic [7:0] btn, input int k);
    if (k < 8) return btn[k] ? 0 : 1;
    return 0;
  endfunction

  function automatic int exp_cnt(input int shifts);
    return (shifts < 8) ? shifts : 8;
  endfunction

  task automatic do_read(input logic [7:0] btn, input int nbits, input int glitch_at,
                         input int glitch_w, input int lo, input int hi);
    int p0;
    btn_in      = btn;
    jp_latch_in = 1'b1;
    tick(12);
    p0          = poll_cnt;
    jp_latch_in = 1'b0;
    tick(12);
    check("poll_pulse", poll_cnt - p0, 1);
    check("cnt_after_latch", int'(shift_cnt_out), 0);
    for (int k = 0; k < nbits; k++) begin
      if (k == glitch_at) begin
        jp_clk_in = 1'b0;
        tick(glitch_w);
        jp_clk_in = 1'b1;
        tick(15);
        check("glitch_cnt", int'(shift_cnt_out), exp_cnt(k));
      end
      jp_clk_in = 1'b0;
      tick(lo);
      check($sformatf("data_bit%0d", k), int'(jp_data_out), exp_bit(btn, k));
      check($sformatf("cnt_bit%0d", k), int'(shift_cnt_out), exp_cnt(k));
      jp_clk_in = 1'b1;
      tick(hi);
    end
    tick(4);
    check("cnt_end", int'(shift_cnt_out), exp_cnt(nbits));
    check("data_end", int'(jp_data_out), exp_bit(btn, nbits));
  endtask

  initial begin
    int p0;
    // Reset then idle
    tick(3);
    check("rst_data", int'(jp_data_out), 1);
    check("rst_poll", int'(poll_out), 0);
    check("rst_cnt", int'(shift_cnt_out), 0);
    p0 = poll_cnt;
    rst_in = 1'b0;
    tick(20);
    check("idle_poll", poll_cnt - p0, 0);
    check("idle_cnt", int'(shift_cnt_out), 0);
    check("idle_data", int'(jp_data_out), 1);

    // Standard read, then a read with overread and a 2-cycle glitch before bit 3
    do_read(8'h09, 8, -1, 0, 20, 20);
    do_read(8'h09, 12, 3, 2, 20, 20);

    // Latch dominance: clock toggles while latched must not shift
    btn_in      = 8'h00;
    jp_latch_in = 1'b1;
    tick(15);
    check("dom_data0", int'(jp_data_out), 1);
    for (int i = 0; i < 3; i++) begin
      jp_clk_in = 1'b0;
      tick(10);
      jp_clk_in = 1'b1;
      tick(10);
    end
    check("dom_cnt", int'(shift_cnt_out), 0);
    btn_in = 8'h01;
    tick(SYNC + FILT + 2);
    check("dom_data1", int'(jp_data_out), 0);
    check("dom_cnt2", int'(shift_cnt_out), 0);
    jp_latch_in = 1'b0;
    tick(15);

    // Reset mid-read discards progress
    do_read(8'hA5, 3, -1, 0, 15, 15);
    rst_in = 1'b1;
    tick(3);
    check("midrst_data", int'(jp_data_out), 1);
    check("midrst_poll", int'(poll_out), 0);
    check("midrst_cnt", int'(shift_cnt_out), 0);
    rst_in = 1'b0;
    tick(10);
    do_read(8'h3C, 8, -1, 0, 15, 15);

    // Randomized reads with random timing, optional glitch and overread
    for (int r = 0; r < 8; r++) begin
      logic [7:0] b;
      int nb, ga, gw, lo, hi;
      b  = 8'($urandom);
      nb = 8 + int'($urandom_range(0, 3));
      ga = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      gw = int'($urandom_range(1, FILT - 1));
      lo = int'($urandom_range(10, 25));
      hi = int'($urandom_range(10, 25));
      do_read(b, nb, ga, gw, lo, hi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jp_responder.md
Name: jp_responder

Overview:
Device-side emulator of an NES standard controller (4021-style shift register). It is the other end of the joypad serial protocol that the rp2a03 drives over jp_clk/jp_latch/jp_data. It samples an 8-bit parallel button vector, answers host latch/clock strobes with serial data, and is used for bench loopback and for driving a second console port from a host or FPGA input source.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the metastability synchronizer on jp_clk_in and jp_latch_in (minimum 2).
FILTER_CYCLES, 4, consecutive equal synchronized samples required before a filtered input level changes (minimum 1).

Ports:
clk_in  input  1  system clock, 100 MHz.
rst_in  input  1  synchronous reset, active-high.
btn_in  input  8  button state, 1 = pressed. Bit order is bit0 A, then B, Select, Start, Up, Down, Left, bit7 Right.
jp_clk_in  input  1  host joypad clock; asynchronous; idles high.
jp_latch_in  input  1  host joypad latch; asynchronous; active-high.
jp_data_out  output  1  serial data line. 0 = pressed. 0 after 8 bits (host reads 1).
poll_out  output  1  one-cycle pulse on each filtered latch falling edge.
shift_cnt_out  output  4  number of bits shifted since the last latch, saturating at 8.

Behaviour:
- Synchronizer: each async input passes through SYNC_STAGES flops.
- Filter: a per-input counter tracks stability. The filtered level takes the synchronized value after FILTER_CYCLES consecutive equal samples. Any mismatch restarts the count.
- Latency: an input pin change reaches the filtered level after SYNC_STAGES+FILTER_CYCLES cycles. The shift register and count update 1 cycle later. jp_data_out is registered and updates 1 cycle after that.
- Edge detect: compare each filtered level with its previous-cycle value. clk_rise = filtered clk 0->1. latch_fall = filtered latch 1->0.
- Internal state: shreg[7:0] and cnt[3:0].
  - LOAD, while filtered latch = 1: shreg <= btn_in every cycle; cnt <= 0; clk edges are ignored.
  - SHIFT, while filtered latch = 0: on clk_rise, shreg <= {1'b0, shreg[7:1]} and cnt <= cnt+1 if cnt<8, otherwise cnt holds at 8.
  - On latch_fall, poll_out = 1 for exactly one cycle and shreg holds the last loaded value.
- Priority:
  - Latch high beats clk_rise in the same cycle: load, no shift.
  - latch_fall coinciding with clk_rise: the latch_fall cycle is treated as the last load; that clk_rise is not shifted.
- jp_data_out (registered): ~shreg[0] when cnt<8, otherwise 0. While latched it reflects ~btn_in[0] (A), delayed 1 cycle.
- shift_cnt_out = cnt.
- Reset values (all registers, synchronous):
  - synchronizer and filtered clk = 1; synchronizer and filtered latch = 0; filter counters = 0.
  - shreg = 0x00; cnt = 0.
  - jp_data_out = 1; poll_out = 0; shift_cnt_out = 0.
  - Reset asserted mid-read discards progress; the next read needs a new latch.
- No spurious edge on reset release: filtered values start at the idle levels.
- Clock pulses on jp_clk_in with high or low time shorter than FILTER_CYCLES cycles are rejected as glitches.
- btn_in is treated as synchronous to clk_in; the source provides that.

Test Plan:
- Reset then idle: hold rst_in 3 cycles with latch=0, clk=1 -> jp_data_out=1, poll_out=0, shift_cnt_out=0, and no edge detected after release.
- Standard read: btn_in=0x09 (A, Start); latch high for 12 cycles; then 8 clk low/high pulses of 20 cycles each -> data sequence 0,1,1,0,1,1,1,1; shift_cnt_out steps 1..8; poll_out high for exactly 1 cycle at latch fall.
- Overread: 4 further clk pulses after a read -> jp_data_out=0 every bit; shift_cnt_out stays 8.
- Glitch rejection: a 2-cycle low pulse on jp_clk_in with FILTER_CYCLES=4 -> no shift, shift_cnt_out unchanged.
- Latch dominance: toggle jp_clk_in while latch high and change btn_in 0x00->0x01 -> shift_cnt_out stays 0; jp_data_out goes 1->0 within SYNC_STAGES+FILTER_CYCLES+2 cycles of the btn_in change.
- Reset mid-read: assert rst_in after 3 shifts -> outputs return to reset values; the next latch/8-clock read returns the full new btn_in pattern.
